// File: rtl/perst_sequencer.sv
// PERST# sequencer: fans one host PERST# out to NUM_PORTS endpoint resets with
// lock qualification, a minimum hold time, staggered release and per-port software pulses.
module perst_sequencer #(
  parameter int NUM_PORTS       = 4,
  parameter int HOLD_CYCLES     = 25000,
  parameter int STAGGER_CYCLES  = 2500,
  parameter int SW_PULSE_CYCLES = 25000,
  parameter int CNT_W           = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 host_perstn,
  input  logic [NUM_PORTS-1:0] refclk_locked,
  input  logic [NUM_PORTS-1:0] sw_rst_req,
  output logic [NUM_PORTS-1:0] port_perstn,
  output logic [NUM_PORTS-1:0] port_up,
  output logic                 seq_busy
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [2:0] ST_ASSERT_ALL = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] ST_HOLD       = 3'd2;
  localparam logic [2:0] ST_RELEASE    = 3'd3;
  localparam logic [2:0] ST_RUN        = 3'd4;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(SW_PULSE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_PORTS - 1);

  logic                             host_meta, host_sync;
  logic [NUM_PORTS-1:0]             lock_meta, lock_sync;
  logic [2:0]                       state, state_nxt;
  logic [CNT_W-1:0]                 cnt, cnt_nxt;
  logic [IDX_W-1:0]                 idx, idx_nxt;
  logic [NUM_PORTS-1:0]             perstn_nxt, port_up_nxt;
  logic                             seq_busy_nxt;
  logic [NUM_PORTS-1:0]             sw_active, sw_active_nxt;
  logic [NUM_PORTS-1:0][CNT_W-1:0]  sw_cnt, sw_cnt_nxt;
  logic                             lock_ok, seq_active, abort;

  assign lock_ok    = &lock_sync;
  assign seq_active = (state == ST_HOLD) || (state == ST_RELEASE) || (state == ST_RUN);
  // Host reset always wins; lock loss only matters once sequencing has begun.
  assign abort      = !host_sync || (seq_active && !lock_ok);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    perstn_nxt    = port_perstn;
    sw_active_nxt = sw_active;
    sw_cnt_nxt    = sw_cnt;
    if (abort) begin
      state_nxt     = ST_ASSERT_ALL;
      cnt_nxt       = '0;
      idx_nxt       = '0;
      perstn_nxt    = '0;
      sw_active_nxt = '0;
      sw_cnt_nxt    = '0;
    end else begin
      case (state)
        ST_ASSERT_ALL: begin
          perstn_nxt = '0;
          state_nxt  = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_ok) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = '0;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt_nxt       = '0;
            idx_nxt       = '0;
            perstn_nxt[0] = 1'b1;
            state_nxt     = (NUM_PORTS == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          // The last port's release and the move to RUN happen on the same edge.
          if (cnt == STAGGER_LAST) begin
            cnt_nxt             = '0;
            idx_nxt             = idx + IDX_W'(1);
            perstn_nxt[idx_nxt] = 1'b1;
            if (idx_nxt == LAST_IDX) state_nxt = ST_RUN;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (sw_rst_req[i]) begin
              sw_active_nxt[i] = 1'b1;
              sw_cnt_nxt[i]    = PULSE_LAST;
              perstn_nxt[i]    = 1'b0;
            end else if (sw_active[i]) begin
              if (sw_cnt[i] == '0) begin
                sw_active_nxt[i] = 1'b0;
                perstn_nxt[i]    = 1'b1;
              end else begin
                sw_cnt_nxt[i] = sw_cnt[i] - CNT_W'(1);
              end
            end
          end
        end
        default: state_nxt = ST_ASSERT_ALL;
      endcase
    end
    port_up_nxt  = (state_nxt == ST_RUN) ? perstn_nxt : '0;
    seq_busy_nxt = (state_nxt != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      host_meta   <= 1'b0;
      host_sync   <= 1'b0;
      lock_meta   <= '0;
      lock_sync   <= '0;
      state       <= ST_ASSERT_ALL;
      cnt         <= '0;
      idx         <= '0;
      port_perstn <= '0;
      port_up     <= '0;
      seq_busy    <= 1'b1;
      sw_active   <= '0;
      sw_cnt      <= '0;
    end else begin
      host_meta   <= host_perstn;
      host_sync   <= host_meta;
      lock_meta   <= refclk_locked;
      lock_sync   <= lock_meta;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      port_perstn <= perstn_nxt;
      port_up     <= port_up_nxt;
      seq_busy    <= seq_busy_nxt;
      sw_active   <= sw_active_nxt;
      sw_cnt      <= sw_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_perst_sequencer.sv
// Self-checking bench for perst_sequencer: reset table, directed multi-cycle
// corner cases and randomized traffic, all checked against a timeline-based model.
module tb_perst_sequencer;

  localparam int NP    = 4;
  localparam int HOLD  = 100;
  localparam int STAG  = 10;
  localparam int PULSE = 50;
  localparam int CW    = 20;
  localparam int RUN_T = HOLD + (NP - 1) * STAG;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          host_perstn = 1'b0;
  logic [NP-1:0] refclk_locked = '0;
  logic [NP-1:0] sw_rst_req = '0;
  logic [NP-1:0] port_perstn, port_up;
  logic          seq_busy;

  perst_sequencer #(
    .NUM_PORTS(NP), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG),
    .SW_PULSE_CYCLES(PULSE), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .host_perstn(host_perstn), .refclk_locked(refclk_locked),
    .sw_rst_req(sw_rst_req), .port_perstn(port_perstn), .port_up(port_up),
    .seq_busy(seq_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: ports open at fixed offsets from the edge lock was qualified.
  logic          hd1, hd2;
  logic [NP-1:0] ld1, ld2;
  int            mode;
  int            start;
  int            pend[NP];
  logic [NP-1:0] exp_perstn, exp_up;
  logic          exp_busy;

  typedef struct {
    logic          r;
    logic          h;
    logic [NP-1:0] l;
    logic [NP-1:0] s;
    logic [NP-1:0] ep;
    logic [NP-1:0] eu;
    logic          eb;
  } vec_t;

  vec_t vecs[12];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic hs;
    logic la;
    int   el;
    if (rst) begin
      hd1 = 1'b0; hd2 = 1'b0; ld1 = '0; ld2 = '0;
      mode = 0; start = 0;
      for (int i = 0; i < NP; i++) pend[i] = 0;
    end else begin
      hs  = hd2;
      la  = (ld2 == {NP{1'b1}});
      hd2 = hd1; hd1 = host_perstn;
      ld2 = ld1; ld1 = refclk_locked;
      if (!hs || (mode == 2 && !la)) begin
        mode = 0;
        for (int i = 0; i < NP; i++) pend[i] = 0;
      end else if (mode == 0) begin
        mode = 1;
      end else if (mode == 1) begin
        if (la) begin
          mode  = 2;
          start = cyc;
        end
      end else if (cyc - start > RUN_T) begin
        for (int i = 0; i < NP; i++) if (sw_rst_req[i]) pend[i] = cyc + PULSE;
      end
    end
    exp_perstn = '0;
    exp_up     = '0;
    exp_busy   = 1'b1;
    if (!rst && mode == 2) begin
      el = cyc - start;
      for (int i = 0; i < NP; i++)
        exp_perstn[i] = (el >= HOLD + i * STAG) && (cyc >= pend[i]);
      if (el >= RUN_T) begin
        exp_busy = 1'b0;
        exp_up   = exp_perstn;
      end
    end
  endtask

  task automatic apply_stimulus();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    check_output("model_perstn", port_perstn, exp_perstn);
    check_output("model_up", port_up, exp_up);
    check_output("model_busy", seq_busy, exp_busy);
  endtask

  task automatic wait_high(input int b, input int budget, output int n);
    n = 0;
    while (port_perstn[b] !== 1'b1 && n < budget) begin
      apply_stimulus();
      n++;
    end
    check_output("wait_port_rise", port_perstn[b], 1'b1);
  endtask

  task automatic pulse_req(input logic [NP-1:0] req);
    sw_rst_req = req;
    apply_stimulus();
    sw_rst_req = '0;
  endtask

  initial begin
    int n;
    int low;
    int host_down;
    int lock_down;
    logic any_high;
    logic others_ok;

    vecs[0]  = '{1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 4'h7, 4'h5, 4'h0, 4'h0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 4'hF, 4'hA, 4'h0, 4'h0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};

    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      rst = vecs[k].r; host_perstn = vecs[k].h;
      refclk_locked = vecs[k].l; sw_rst_req = vecs[k].s;
      apply_stimulus();
      check_output($sformatf("vec%0d_perstn", k), port_perstn, vecs[k].ep);
      check_output($sformatf("vec%0d_up", k), port_up, vecs[k].eu);
      check_output($sformatf("vec%0d_busy", k), seq_busy, vecs[k].eb);
    end
    sw_rst_req = '0;

    // Power-up: 2 sync + ASSERT_ALL + WAIT_LOCK edges, then HOLD.
    rst = 1'b0;
    wait_high(0, 2000, n);
    check_output("powerup_p0_delay", n, 104);
    for (int i = 1; i < NP; i++) begin
      wait_high(i, 200, n);
      check_output($sformatf("powerup_p%0d_stagger", i), n, STAG);
    end
    check_output("powerup_busy", seq_busy, 1'b0);
    check_output("powerup_up", port_up, 4'hF);

    // Software pulse on ports 0 and 2.
    pulse_req(4'b0101);
    check_output("pulse_perstn", port_perstn, 4'b1010);
    check_output("pulse_up", port_up, 4'b1010);
    low = 1;
    others_ok = 1'b1;
    for (int k = 0; k < 500; k++) begin
      apply_stimulus();
      if (port_perstn[1] !== 1'b1 || port_perstn[3] !== 1'b1) others_ok = 1'b0;
      if (port_perstn[0] === 1'b0) low++;
      else break;
    end
    check_output("pulse_len", low, PULSE);
    check_output("pulse_others", others_ok, 1'b1);
    check_output("pulse_end_all", port_perstn, 4'hF);

    // Re-request at cycle 30 of the pulse extends it to 80 cycles.
    pulse_req(4'b0001);
    low = 1;
    for (int k = 0; k < 29; k++) begin
      apply_stimulus();
      if (port_perstn[0] === 1'b0) low++;
    end
    pulse_req(4'b0001);
    if (port_perstn[0] === 1'b0) low++;
    for (int k = 0; k < 500; k++) begin
      apply_stimulus();
      if (port_perstn[0] === 1'b0) low++;
      else break;
    end
    check_output("extend_len", low, 80);

    // Lock loss in RUN, then relock.
    refclk_locked = 4'b0111;
    repeat (3) apply_stimulus();
    check_output("lockloss_perstn", port_perstn, 4'h0);
    check_output("lockloss_busy", seq_busy, 1'b1);
    refclk_locked = 4'hF;
    wait_high(0, 2000, n);
    check_output("relock_p0_delay", n, 103);
    wait_high(1, 200, n);
    wait_high(2, 200, n);

    // Host reset while idx=2.
    host_perstn = 1'b0;
    repeat (3) apply_stimulus();
    check_output("midrel_perstn", port_perstn, 4'h0);
    check_output("midrel_busy", seq_busy, 1'b1);
    repeat (5) apply_stimulus();
    host_perstn = 1'b1;
    wait_high(0, 2000, n);
    check_output("midrel_restart_p0", n, 104);
    wait_high(3, 200, n);
    check_output("midrel_restart_p3", n, 3 * STAG);

    // Lock gating plus requests outside RUN.
    refclk_locked = 4'b0111;
    any_high = 1'b0;
    for (int k = 0; k < 500; k++) begin
      sw_rst_req = (k == 200) ? 4'hF : 4'h0;
      apply_stimulus();
      if (k >= 3 && port_perstn !== 4'h0) any_high = 1'b1;
    end
    sw_rst_req = '0;
    check_output("lockgate_low", any_high, 1'b0);
    refclk_locked = 4'hF;
    repeat (50) apply_stimulus();
    pulse_req(4'hF);
    wait_high(0, 2000, n);
    check_output("lockgate_p0_delay", n, 103 - 51);
    wait_high(3, 200, n);
    repeat (5) apply_stimulus();
    check_output("hold_req_ignored", port_perstn, 4'hF);

    // Randomized traffic against the model.
    host_down = 0;
    lock_down = 0;
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < NP; i++) sw_rst_req[i] = ($urandom_range(63) == 0);
      if (host_down > 0) host_down--;
      else if ($urandom_range(999) == 0) host_down = $urandom_range(30, 1);
      host_perstn = (host_down == 0);
      if (lock_down > 0) lock_down--;
      else if ($urandom_range(1499) == 0) lock_down = $urandom_range(40, 1);
      refclk_locked = (lock_down == 0) ? 4'hF : ~(4'b0001 << (k % NP));
      apply_stimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/perst_sequencer.md
Name: perst_sequencer

Overview:
- Generalised PERST# controller for the FPGA shell: one host-facing PCIe reset input fans out to NUM_PORTS downstream endpoint reset outputs (NVMe/OpenCAPI-style links).
- Enforces a minimum assertion time and a refclk-lock qualification before any release.
- Releases ports in staggered order to limit inrush and link-training contention.
- Supports per-port software-initiated reset pulses while the host link is up.

Parameters:
- NUM_PORTS, 4, number of downstream PERST# outputs (1..16).
- HOLD_CYCLES, 25000, minimum cycles all ports stay asserted after host_perstn rises and lock is seen (100 us at 250 MHz).
- STAGGER_CYCLES, 2500, cycles between successive port releases.
- SW_PULSE_CYCLES, 25000, assertion length of a software-requested port reset.
- CNT_W, 20, counter width; must hold max(HOLD_CYCLES, STAGGER_CYCLES, SW_PULSE_CYCLES).

Ports:
- clk  in  1  free-running shell clock.
- rst  in  1  synchronous active-high reset.
- host_perstn  in  1  host PERST#, active-low, asynchronous to clk.
- refclk_locked  in  NUM_PORTS  per-port reference clock/GT PLL lock, asynchronous.
- sw_rst_req  in  NUM_PORTS  per-port single-cycle software reset request, clk domain.
- port_perstn  out  NUM_PORTS  downstream PERST#, active-low.
- port_up  out  NUM_PORTS  port released and not in a software pulse.
- seq_busy  out  1  sequencer not in RUN.

Behaviour:
- Synchronisers: host_perstn and each refclk_locked bit pass through 2-flop synchronisers before use. Synchroniser flops reset to 0.
- Reset state (rst=1): state=ASSERT_ALL, counters=0, port_perstn=all 0, port_up=all 0, seq_busy=1.
- ASSERT_ALL:
  - All ports asserted.
  - Go to WAIT_LOCK when synced host_perstn=1.
- WAIT_LOCK:
  - Stay until synced refclk_locked is all 1s.
  - Then go to HOLD with the counter cleared.
- HOLD:
  - Count to HOLD_CYCLES-1, then go to RELEASE with idx=0.
  - On the transition cycle, port_perstn[0] rises; it is visible the following cycle (registered output).
- RELEASE:
  - port_perstn[idx] is set to 1.
  - Counter counts STAGGER_CYCLES-1, then idx increments and the next port releases.
  - After port NUM_PORTS-1 releases, go to RUN.
  - Ports release strictly in index order; a released port stays released.
- RUN:
  - seq_busy=0.
  - port_up[i] = port_perstn[i] and not in a software pulse.
- Software pulse:
  - Honoured only in RUN.
  - sw_rst_req[i]=1 drives port_perstn[i]=0 on the next cycle and loads a per-port counter. The port stays low for exactly SW_PULSE_CYCLES cycles, then returns to 1.
  - Each port has an independent counter, so simultaneous requests on several ports run in parallel.
  - A request on a port already pulsing restarts its counter (extends the pulse).
  - Requests outside RUN are ignored and discarded (no queueing).
- Host reset mid-operation: synced host_perstn=0 in any state returns to ASSERT_ALL on the next cycle.
  - All port_perstn drop to 0 the same cycle as the transition; this is asserted within 3 clk of the host_perstn falling edge (2 sync + 1 register).
  - Software pulse counters clear; idx clears.
- Lock loss: any synced refclk_locked bit falling to 0 in HOLD, RELEASE or RUN behaves as a host reset (go to ASSERT_ALL); the sequence restarts from WAIT_LOCK once host_perstn is high.
- Priority: rst > host_perstn low > lock loss > software request > sequencing.
- NUM_PORTS=1: RELEASE goes to RUN immediately after releasing port 0 with no stagger wait.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Power-up: rst for 4 cycles, host_perstn=1, locked=all 1s, NUM_PORTS=4, HOLD=100, STAGGER=10 -> port 0 rises 3+100 cycles after rst release (±1); ports 1/2/3 follow at +10/+20/+30; seq_busy falls with port 3; port_up=4'b1111.
- Lock gating: host_perstn=1, locked=4'b0111 for 500 cycles, then 4'b1111 -> port_perstn stays 0 throughout; HOLD counting starts only after the sync delay following full lock.
- Mid-release host reset: drop host_perstn while idx=2 -> port_perstn=4'b0000 within 3 cycles; on re-raise the full sequence restarts from port 0 with the full HOLD.
- Software pulse: in RUN, sw_rst_req=4'b0101 for 1 cycle, SW_PULSE=50 -> ports 0 and 2 are low for exactly 50 cycles; port_up=4'b1010 during the pulse; ports 1 and 3 are unaffected.
- Pulse extension and ignore:
  - Re-request port 0 at cycle 30 of its pulse -> it stays low until cycle 80.
  - A request during HOLD has no effect after RUN is reached.
- Lock loss in RUN: deassert locked[3] -> all ports asserted within 3 cycles; seq_busy=1; sequence resumes after relock.
